// File: rtl/vcm_step_i2c_writer.sv
// -----------------------------------------------------------------------------
// vcm_step_i2c_writer
//
// Writes a 10-bit lens position to the D8M voice-coil-motor driver as a single
// 3-byte I2C write frame: {DEV_ADDR,W}, {PD=0,FLAG=0,STEP[9:4]},
// {STEP[3:0],SLEW}. While a frame is in flight VCM_RELAESE is held low so the
// top-level SCL mux hands the bus to this block.
//
// Optional feature: define VCM_RETRY_EN to re-run a NACKed frame (same latched
// bytes) up to 3 more times before reporting ACK_ERR.
//
// Parameters
//   QTR       CLK_50 cycles per SCL quarter-period
//   SLEW      slew code, low nibble of the last data byte
//   DEV_ADDR  7-bit I2C address of the VCM driver
//
// Ports
//   CLK_50       in   system clock
//   RESET_N      in   asynchronous active-low reset
//   GO           in   one-cycle write request, honoured only while VCM_RELAESE=1
//   STEP[9:0]    in   lens position, latched on an accepted GO
//   I2C_SCL      out  SCL (idle high)
//   I2C_SDA      io   open-drain SDA: drives 0 or Z only
//   VCM_RELAESE  out  1 = bus released / idle, 0 = frame in progress
//   DONE         out  one-cycle pulse in the last cycle of a frame
//   ACK_ERR      out  sticky NACK flag, cleared by the next accepted GO
// -----------------------------------------------------------------------------
module vcm_step_i2c_writer #(
  parameter int         QTR      = 31,
  parameter logic [3:0] SLEW     = 4'h0,
  parameter logic [6:0] DEV_ADDR = 7'h0C
) (
  input  logic       CLK_50,
  input  logic       RESET_N,
  input  logic       GO,
  input  logic [9:0] STEP,
  output logic       I2C_SCL,
  inout  wire        I2C_SDA,
  output logic       VCM_RELAESE,
  output logic       DONE,
  output logic       ACK_ERR
);

  localparam int QW = (QTR > 1) ? $clog2(QTR) : 1;

  typedef enum logic [2:0] {IDLE, START, BITS, STOP, FREE} state_t;

  state_t        state_reg,   state_next;
  logic [QW-1:0] qcnt_reg,    qcnt_next;
  logic [1:0]    quarter_reg, quarter_next;
  logic [4:0]    slot_reg,    slot_next;
  logic [26:0]   seq_reg,     seq_next;
  logic          nack_reg,    nack_next;
  logic          ack_err_reg, ack_err_next;
`ifdef VCM_RETRY_EN
  logic [1:0]    retry_reg,   retry_next;
`endif

  logic       tick;
  logic       slot_is_ack;
  logic       last_try;
  logic [4:0] bit_idx;
  logic       sda_in;
  logic       scl_level;
  logic       sda_low;
  logic       done_pulse;
  logic       rel_level;

  assign sda_in      = I2C_SDA;
  assign tick        = (qcnt_reg == QW'(QTR - 1));
  // Every ninth slot is the slave's ACK slot; the master releases SDA there.
  assign slot_is_ack = (slot_reg == 5'd8) || (slot_reg == 5'd17) || (slot_reg == 5'd26);
  assign bit_idx     = 5'd26 - slot_reg;

`ifdef VCM_RETRY_EN
  assign last_try = (retry_reg == 2'd3);
`else
  assign last_try = 1'b1;
`endif

  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg   <= IDLE;
      qcnt_reg    <= '0;
      quarter_reg <= '0;
      slot_reg    <= '0;
      seq_reg     <= '1;
      nack_reg    <= 1'b0;
      ack_err_reg <= 1'b0;
`ifdef VCM_RETRY_EN
      retry_reg   <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      qcnt_reg    <= qcnt_next;
      quarter_reg <= quarter_next;
      slot_reg    <= slot_next;
      seq_reg     <= seq_next;
      nack_reg    <= nack_next;
      ack_err_reg <= ack_err_next;
`ifdef VCM_RETRY_EN
      retry_reg   <= retry_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    qcnt_next    = qcnt_reg;
    quarter_next = quarter_reg;
    slot_next    = slot_reg;
    seq_next     = seq_reg;
    nack_next    = nack_reg;
    ack_err_next = ack_err_reg;
`ifdef VCM_RETRY_EN
    retry_next   = retry_reg;
`endif
    scl_level    = 1'b1;
    sda_low      = 1'b0;
    done_pulse   = 1'b0;

    // Quarter timebase only runs inside a frame. Every phase ends on q3, so
    // the 2-bit quarter counter wraps to 0 exactly at each phase change.
    if (state_reg != IDLE) begin
      qcnt_next = tick ? '0 : qcnt_reg + QW'(1);
      if (tick) begin
        quarter_next = quarter_reg + 2'd1;
      end
    end

    case (state_reg)
      START: begin
        scl_level = (quarter_reg != 2'd3);
        sda_low   = quarter_reg[1];
        if (tick && quarter_reg == 2'd3) begin
          state_next = BITS;
          slot_next  = '0;
        end
      end
      BITS: begin
        scl_level = (quarter_reg == 2'd1) || (quarter_reg == 2'd2);
        // ACK slots are stored as 1 in the sequence, so they release SDA.
        sda_low   = ~seq_reg[bit_idx];
        if (tick && quarter_reg == 2'd2 && slot_is_ack) begin
          nack_next = sda_in;
        end
        if (tick && quarter_reg == 2'd3) begin
          if (slot_is_ack && nack_reg) begin
            state_next = STOP;
            if (last_try) begin
              ack_err_next = 1'b1;
            end
          end else if (slot_reg == 5'd26) begin
            state_next = STOP;
          end else begin
            slot_next = slot_reg + 5'd1;
          end
        end
      end
      STOP: begin
        scl_level = (quarter_reg != 2'd0);
        sda_low   = ~quarter_reg[1];
        if (tick && quarter_reg == 2'd3) begin
          state_next = FREE;
        end
      end
      FREE: begin
        if (tick && quarter_reg == 2'd3) begin
`ifdef VCM_RETRY_EN
          if (nack_reg && !last_try) begin
            state_next = START;
            retry_next = retry_reg + 2'd1;
          end else begin
            state_next = IDLE;
            done_pulse = 1'b1;
          end
`else
          state_next = IDLE;
          done_pulse = 1'b1;
`endif
        end
      end
      default: begin
      end
    endcase

    // The bus is handed back in the DONE cycle itself, so a GO arriving
    // together with DONE chains straight into a new frame.
    rel_level = (state_reg == IDLE) || done_pulse;

    if (GO && rel_level) begin
      state_next   = START;
      qcnt_next    = '0;
      quarter_next = 2'd0;
      slot_next    = '0;
      seq_next     = {DEV_ADDR, 1'b0, 1'b1,
                      2'b00, STEP[9:4], 1'b1,
                      STEP[3:0], SLEW, 1'b1};
      ack_err_next = 1'b0;
      nack_next    = 1'b0;
`ifdef VCM_RETRY_EN
      retry_next   = '0;
`endif
    end
  end

  assign I2C_SCL     = scl_level;
  assign I2C_SDA     = sda_low ? 1'b0 : 1'bz;
  assign VCM_RELAESE = rel_level;
  assign DONE        = done_pulse;
  assign ACK_ERR     = ack_err_reg;

endmodule
